// File: rtl/rcc_pkg.sv
// Shared types and defaults for the domain reset/clock sequencer.
package rcc_pkg;

  // Per-domain FSM state encoding
  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_CLK_WAIT = 3'd2,
    ST_RUN      = 3'd3,
    ST_STOP     = 3'd4
  } dom_st_e;

  localparam int RST_DUR_DEF    = 10;
  localparam int CLK_ON_DLY_DEF = 8;

  // Per-domain request bundle (sliced out of the top-level vectors)
  typedef struct packed {
    logic pwr_ok;
    logic sw_rst;
    logic sleep;
    logic busy;
    logic wkup;
  } dom_req_t;

  // Per-domain response bundle
  typedef struct packed {
    logic rst_n;
    logic clk_en;
    logic stop_req;
    logic run;
  } dom_rsp_t;

  // Counter width wide enough for the longer of the two timed phases
  function automatic int cnt_w(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/rcc_dom_rst_fsm.sv
// One power domain: OFF -> RST_HOLD -> CLK_WAIT -> RUN <-> STOP sequencer.
module rcc_dom_rst_fsm
  import rcc_pkg::*;
#(
  parameter int RST_DUR    = RST_DUR_DEF,
  parameter int CLK_ON_DLY = CLK_ON_DLY_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     arcg_on,
  input  dom_req_t req,
  output dom_rsp_t rsp
);

  localparam int CW = cnt_w(RST_DUR, CLK_ON_DLY);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_DUR - 1);
  // Only meaningful when CLK_ON_DLY > 0; the zero case bypasses CLK_WAIT
  localparam logic [CW-1:0] WAIT_LAST = CW'(CLK_ON_DLY - 1);

  dom_st_e       st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  dom_rsp_t      rsp_nxt;

  // State, counter and decoded outputs are all registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= ST_OFF;
      cnt <= '0;
      rsp <= '0;
    end else begin
      st  <= st_nxt;
      cnt <= cnt_nxt;
      rsp <= rsp_nxt;
    end
  end

  // Next state: power loss beats software reset beats normal flow
  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    if (!req.pwr_ok) begin
      st_nxt = ST_OFF;
    end else if (req.sw_rst) begin
      st_nxt = ST_RST_HOLD;
    end else begin
      case (st)
        ST_OFF:      st_nxt = ST_RST_HOLD;
        ST_RST_HOLD: begin
          if (cnt == HOLD_LAST) st_nxt = (CLK_ON_DLY > 0) ? ST_CLK_WAIT : ST_RUN;
          else                  cnt_nxt = cnt + CW'(1);
        end
        ST_CLK_WAIT: begin
          if (cnt == WAIT_LAST) st_nxt = ST_RUN;
          else                  cnt_nxt = cnt + CW'(1);
        end
        ST_RUN:      if (req.sleep && !req.busy) st_nxt = ST_STOP;
        ST_STOP:     if (req.wkup) st_nxt = ST_RUN;
        default:     st_nxt = ST_OFF;
      endcase
    end
  end

  // Output decode from the next state so outputs land with the state change
  always_comb begin
    rsp_nxt = '0;
    case (st_nxt)
      ST_RST_HOLD: rsp_nxt.clk_en = 1'b1;
      ST_CLK_WAIT: begin
        rsp_nxt.rst_n  = 1'b1;
        rsp_nxt.clk_en = ~arcg_on;
      end
      ST_RUN: begin
        rsp_nxt.rst_n  = 1'b1;
        rsp_nxt.clk_en = 1'b1;
        rsp_nxt.run    = 1'b1;
      end
      ST_STOP: begin
        rsp_nxt.rst_n    = 1'b1;
        rsp_nxt.stop_req = 1'b1;
      end
      default: rsp_nxt = '0;
    endcase
  end

endmodule

// File: rtl/rcc_dom_rst_seq.sv
// Top level: one independent sequencer per power domain.
module rcc_dom_rst_seq
  import rcc_pkg::*;
#(
  parameter int NDOM       = 3,
  parameter int RST_DUR    = RST_DUR_DEF,
  parameter int CLK_ON_DLY = CLK_ON_DLY_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            arcg_on,
  input  logic [NDOM-1:0] dom_pwr_ok,
  input  logic [NDOM-1:0] dom_sw_rst,
  input  logic [NDOM-1:0] dom_sleep,
  input  logic [NDOM-1:0] dom_busy,
  input  logic [NDOM-1:0] dom_wkup,
  output logic [NDOM-1:0] dom_rst_n,
  output logic [NDOM-1:0] dom_clk_en,
  output logic [NDOM-1:0] dom_stop_req,
  output logic [NDOM-1:0] dom_run
);

  for (genvar d = 0; d < NDOM; d++) begin : g_dom
    dom_req_t req;
    dom_rsp_t rsp;

    assign req = '{pwr_ok: dom_pwr_ok[d], sw_rst: dom_sw_rst[d], sleep: dom_sleep[d],
                   busy: dom_busy[d], wkup: dom_wkup[d]};

    rcc_dom_rst_fsm #(
      .RST_DUR    (RST_DUR),
      .CLK_ON_DLY (CLK_ON_DLY)
    ) u_fsm (
      .clk     (clk),
      .rst_n   (rst_n),
      .arcg_on (arcg_on),
      .req     (req),
      .rsp     (rsp)
    );

    assign dom_rst_n[d]    = rsp.rst_n;
    assign dom_clk_en[d]   = rsp.clk_en;
    assign dom_stop_req[d] = rsp.stop_req;
    assign dom_run[d]      = rsp.run;
  end

endmodule
